stepper_move_sequencer: RTL

Two-axis move sequencer that drives a pair of step-pulse controllers (X and Y). It accepts signed move commands wider than the controllers' step-count field and splits each into segments that fit that field. For each segment it triggers both axes together and waits for both to report done before issuing the next. It sits between the motion command decoder and the per-axis stepper controllers.

---
 rtl/stepper_move_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/stepper_move_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stepper_move_sequencer                                       |
// | Description : Two-axis move sequencer. It accepts signed X/Y move commands |
// |               wider than the controllers' step-count field and splits each |
// |               move into segments of at most SEG_MAX steps per axis. For    |
// |               each segment it triggers both axes together, then waits for  |
// |               both to report done before issuing the next segment.         |
// | Ports       : i_clk/i_reset/i_clk_en     clock, sync reset, tick enable    |
// |               i_cmd_*, o_cmd_ready       move command handshake            |
// |               i_abort                    stop after the current segment    |
// |               o_x/y_num_steps, o_pulse_width, o_x/y_trigger  to controllers|
// |               i_x/y_done                 controller idle flags             |
// |               o_busy, o_move_done        sequencer status                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stepper_move_sequencer #(
  parameter int CMD_BITS   = 16,
  parameter int COUNT_BITS = 8,
  parameter int WIDTH_BITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_en,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [CMD_BITS-1:0]   i_cmd_dx,
  input  logic [CMD_BITS-1:0]   i_cmd_dy,
  input  logic [WIDTH_BITS-1:0] i_cmd_pulse_width,
  input  logic                  i_abort,
  output logic [COUNT_BITS-1:0] o_x_num_steps,
  output logic [COUNT_BITS-1:0] o_y_num_steps,
  output logic [WIDTH_BITS-1:0] o_pulse_width,
  output logic                  o_x_trigger,
  output logic                  o_y_trigger,
  input  logic                  i_x_done,
  input  logic                  i_y_done,
  output logic                  o_busy,
  output logic                  o_move_done
);

  // Largest segment magnitude that fits the signed step-count field.
  localparam logic [COUNT_BITS-1:0] c_SEG_MAX     = {1'b0, {(COUNT_BITS-1){1'b1}}};
  localparam logic [CMD_BITS-1:0]   c_SEG_MAX_CMD = CMD_BITS'(c_SEG_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_TRIG   = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_sign_x;
  logic                  r_sign_y;
  logic [CMD_BITS-1:0]   r_rem_x;
  logic [CMD_BITS-1:0]   r_rem_y;
  logic [COUNT_BITS-1:0] r_x_num;
  logic [COUNT_BITS-1:0] r_y_num;
  logic [WIDTH_BITS-1:0] r_pw;
  logic                  r_x_act;
  logic                  r_y_act;
  logic                  r_abort_pending;

  logic [CMD_BITS-1:0]   w_abs_dx;
  logic [CMD_BITS-1:0]   w_abs_dy;
  logic [COUNT_BITS-1:0] w_mag_x;
  logic [COUNT_BITS-1:0] w_mag_y;
  logic                  w_load_done;
  logic                  w_x_ok;
  logic                  w_y_ok;

  // Magnitudes are kept unsigned at full command width so that the most
  // negative command (-2^(CMD_BITS-1)) maps to its true magnitude.
  assign w_abs_dx    = i_cmd_dx[CMD_BITS-1] ? (-i_cmd_dx) : i_cmd_dx;
  assign w_abs_dy    = i_cmd_dy[CMD_BITS-1] ? (-i_cmd_dy) : i_cmd_dy;
  assign w_mag_x     = (r_rem_x > c_SEG_MAX_CMD) ? c_SEG_MAX : r_rem_x[COUNT_BITS-1:0];
  assign w_mag_y     = (r_rem_y > c_SEG_MAX_CMD) ? c_SEG_MAX : r_rem_y[COUNT_BITS-1:0];
  assign w_load_done = ((r_rem_x == '0) && (r_rem_y == '0)) || r_abort_pending;

  // An axis that was not triggered in this segment never holds up the wait.
  assign w_x_ok = !r_x_act || i_x_done;
  assign w_y_ok = !r_y_act || i_y_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else if (i_clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_cmd_valid) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = w_load_done ? S_FINISH : S_TRIG;
      S_TRIG:   w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_x_ok && w_y_ok) w_state_nxt = S_LOAD;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sign_x        <= 1'b0;
      r_sign_y        <= 1'b0;
      r_rem_x         <= '0;
      r_rem_y         <= '0;
      r_x_num         <= '0;
      r_y_num         <= '0;
      r_pw            <= '0;
      r_x_act         <= 1'b0;
      r_y_act         <= 1'b0;
      r_abort_pending <= 1'b0;
    end else if (i_clk_en) begin
      if ((r_state == S_IDLE) && i_cmd_valid) begin
        r_sign_x <= i_cmd_dx[CMD_BITS-1];
        r_sign_y <= i_cmd_dy[CMD_BITS-1];
        r_rem_x  <= w_abs_dx;
        r_rem_y  <= w_abs_dy;
        r_pw     <= i_cmd_pulse_width;
      end

      // Step counts are only rewritten when a real segment is issued, so they
      // stay stable from one segment load to the next.
      if ((r_state == S_LOAD) && !w_load_done) begin
        r_x_num <= r_sign_x ? (-w_mag_x) : w_mag_x;
        r_y_num <= r_sign_y ? (-w_mag_y) : w_mag_y;
        r_rem_x <= r_rem_x - CMD_BITS'(w_mag_x);
        r_rem_y <= r_rem_y - CMD_BITS'(w_mag_y);
        r_x_act <= (w_mag_x != '0);
        r_y_act <= (w_mag_y != '0);
      end

      // Leaving FINISH enters IDLE: drop any aborted remainder and the abort.
      if (r_state == S_FINISH) begin
        r_rem_x         <= '0;
        r_rem_y         <= '0;
        r_abort_pending <= 1'b0;
      end else if ((r_state != S_IDLE) && i_abort) begin
        r_abort_pending <= 1'b1;
      end
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_move_done   = (r_state == S_FINISH);
  assign o_x_trigger   = (r_state == S_TRIG) && r_x_act;
  assign o_y_trigger   = (r_state == S_TRIG) && r_y_act;
  assign o_x_num_steps = r_x_num;
  assign o_y_num_steps = r_y_num;
  assign o_pulse_width = r_pw;

endmodule
`default_nettype wire
